// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command parser.
// Command bytes, response byte, field lengths and the parser state type.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_TX      = 3'd5,
    ST_TX_WAIT = 3'd6
  } state_e;

  function automatic logic [23:0] shift_addr(input logic [23:0] addr, input logic [7:0] b);
    return {addr[15:0], b};
  endfunction

  function automatic logic [15:0] shift_data(input logic [15:0] data, input logic [7:0] b);
    return {data[7:0], b};
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte gap timer: reloads on every byte or while idle, counts down while running,
// and flags expiry once the full gap has elapsed without a reload.
module uart_cmd_timer #(
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_reload,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          zero_r;

  // Next count: reload when a byte arrives or when not running, otherwise count down to zero.
  always_comb begin
    cnt_s = cnt_r;
    if (i_reload || !i_run) begin
      cnt_s = LOAD_VAL;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_s = cnt_r - CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Count register plus a registered zero flag so the expiry output comes straight from a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r  <= {CW{1'b0}};
      zero_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      zero_r <= (cnt_s == {CW{1'b0}});
    end
  end

  assign o_expired = zero_r;

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser between the UART receiver/transmitter and the SDRAM controller.
// Assembles W/R commands, issues them over valid/ready, and returns an ACK or read data.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_wr,
  output logic [23:0] o_cmd_addr,
  output logic [15:0] o_cmd_wdata,
  input  logic        i_rd_valid,
  input  logic [15:0] i_rd_data,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  output logic        o_err
);

  state_e      state_r, state_s;
  logic [1:0]  byte_cnt_r, byte_cnt_s;
  logic        wr_r, wr_s;
  logic [23:0] addr_r, addr_s;
  logic [15:0] wdata_r, wdata_s;
  logic [15:0] rd_data_r, rd_data_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        guard_r, guard_s;
  logic        last_byte_r, last_byte_s;
  logic        cmd_valid_r, tx_start_r, err_r, err_s;
  logic        run_s, expired_s;

  assign run_s = (state_r == ST_ADDR) || (state_r == ST_DATA);

  uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (run_s),
    .i_reload  (i_rx_done),
    .o_expired (expired_s)
  );

  // Next-state and datapath decode; a byte always takes priority over a same-cycle timeout.
  always_comb begin
    state_s     = state_r;
    byte_cnt_s  = byte_cnt_r;
    wr_s        = wr_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rd_data_s   = rd_data_r;
    tx_data_s   = tx_data_r;
    guard_s     = guard_r;
    last_byte_s = last_byte_r;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_done) begin
          if ((i_rx_data == CMD_WR) || (i_rx_data == CMD_RD)) begin
            state_s    = ST_ADDR;
            byte_cnt_s = 2'd0;
            wr_s       = (i_rx_data == CMD_WR);
            addr_s     = 24'h000000;
            wdata_s    = 16'h0000;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (i_rx_done) begin
          addr_s = shift_addr(addr_r, i_rx_data);
          if (byte_cnt_r == 2'(ADDR_BYTES - 1)) begin
            byte_cnt_s = 2'd0;
            state_s    = wr_r ? ST_DATA : ST_ISSUE;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else if (expired_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (i_rx_done) begin
          wdata_s = shift_data(wdata_r, i_rx_data);
          if (byte_cnt_r == 2'(DATA_BYTES - 1)) begin
            byte_cnt_s = 2'd0;
            state_s    = ST_ISSUE;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else if (expired_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_ISSUE: begin
        err_s = i_rx_done;
        if (i_cmd_ready) begin
          if (wr_r) begin
            state_s     = ST_TX;
            tx_data_s   = ACK_BYTE;
            last_byte_s = 1'b1;
          end else begin
            state_s = ST_WAIT_RD;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        err_s = i_rx_done;
        if (i_rd_valid) begin
          rd_data_s   = i_rd_data;
          tx_data_s   = i_rd_data[15:8];
          last_byte_s = 1'b0;
          state_s     = ST_TX;
        end else begin
          state_s = ST_WAIT_RD;
        end
      end
      ST_TX: begin
        err_s   = i_rx_done;
        guard_s = 1'b1;
        state_s = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        err_s = i_rx_done;
        // The transmitter may not have raised busy yet, so skip the first cycle.
        if (guard_r) begin
          guard_s = 1'b0;
        end else if (!i_tx_busy) begin
          if (last_byte_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s     = ST_TX;
            tx_data_s   = rd_data_r[7:0];
            last_byte_s = 1'b1;
          end
        end else begin
          state_s = ST_TX_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      byte_cnt_r  <= 2'd0;
      wr_r        <= 1'b0;
      addr_r      <= 24'h000000;
      wdata_r     <= 16'h0000;
      rd_data_r   <= 16'h0000;
      tx_data_r   <= 8'h00;
      guard_r     <= 1'b0;
      last_byte_r <= 1'b0;
      cmd_valid_r <= 1'b0;
      tx_start_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      byte_cnt_r  <= byte_cnt_s;
      wr_r        <= wr_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rd_data_r   <= rd_data_s;
      tx_data_r   <= tx_data_s;
      guard_r     <= guard_s;
      last_byte_r <= last_byte_s;
      cmd_valid_r <= (state_s == ST_ISSUE);
      tx_start_r  <= (state_s == ST_TX);
      err_r       <= err_s;
    end
  end

  assign o_cmd_valid = cmd_valid_r;
  assign o_cmd_wr    = wr_r;
  assign o_cmd_addr  = addr_r;
  assign o_cmd_wdata = wdata_r;
  assign o_tx_start  = tx_start_r;
  assign o_tx_data   = tx_data_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: write, read, unknown byte, timeout, stall drop, reset abort.
// Inputs change 1 time unit after the rising edge, where outputs are also sampled.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        o_cmd_valid;
  logic        i_cmd_ready = 1'b0;
  logic        o_cmd_wr;
  logic [23:0] o_cmd_addr;
  logic [15:0] o_cmd_wdata;
  logic        i_rd_valid = 1'b0;
  logic [15:0] i_rd_data = 16'h0000;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy = 1'b0;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int tx_seen = 0;
  int wait_cycles = 0;

  uart_cmd_parser #(.TIMEOUT_CLKS(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .o_cmd_wr    (o_cmd_wr),
    .o_cmd_addr  (o_cmd_addr),
    .o_cmd_wdata (o_cmd_wdata),
    .i_rd_valid  (i_rd_valid),
    .i_rd_data   (i_rd_data),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Count error pulses and transmit requests across the whole run.
  always @(negedge i_clk) begin
    if (o_err === 1'b1) err_seen <= err_seen + 1;
    if (o_tx_start === 1'b1) tx_seen <= tx_seen + 1;
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic accept;
    i_cmd_ready = 1'b1;
    tick();
    i_cmd_ready = 1'b0;
  endtask

  task automatic finish_tx(input int n);
    i_tx_busy = 1'b1;
    repeat (n) tick();
    chk("no_start_while_busy", 32'(o_tx_start), 32'd0);
    i_tx_busy = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_cmd_valid), 32'd0);
    chk({tag, "_wr"},    32'(o_cmd_wr),    32'd0);
    chk({tag, "_addr"},  32'(o_cmd_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(o_cmd_wdata), 32'd0);
    chk({tag, "_start"}, 32'(o_tx_start),  32'd0);
    chk({tag, "_txd"},   32'(o_tx_data),   32'd0);
    chk({tag, "_err"},   32'(o_err),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk_all_zero("reset");
    i_rst = 1'b0;
    tick();

    // Write 0x123456 <= 0xABCD, held until ready
    send(8'h57); send(8'h12); send(8'h34); send(8'h56); send(8'hAB);
    chk("wr_valid_early", 32'(o_cmd_valid), 32'd0);
    send(8'hCD);
    chk("wr_valid", 32'(o_cmd_valid), 32'd1);
    chk("wr_flag",  32'(o_cmd_wr),    32'd1);
    chk("wr_addr",  32'(o_cmd_addr),  32'h123456);
    chk("wr_wdata", 32'(o_cmd_wdata), 32'hABCD);
    repeat (3) tick();
    chk("wr_hold_valid", 32'(o_cmd_valid), 32'd1);
    chk("wr_hold_addr",  32'(o_cmd_addr),  32'h123456);
    accept();
    chk("wr_ack_start", 32'(o_tx_start),  32'd1);
    chk("wr_ack_data",  32'(o_tx_data),   32'h4B);
    chk("wr_valid_off", 32'(o_cmd_valid), 32'd0);
    finish_tx(2);
    chk("wr_tx_count", 32'(tx_seen), 32'd1);

    // Read 0x000010, data 0xBEEF three cycles after accept
    send(8'h52); send(8'h00); send(8'h00); send(8'h10);
    chk("rd_valid", 32'(o_cmd_valid), 32'd1);
    chk("rd_flag",  32'(o_cmd_wr),    32'd0);
    chk("rd_addr",  32'(o_cmd_addr),  32'h000010);
    chk("rd_wdata", 32'(o_cmd_wdata), 32'd0);
    accept();
    tick();
    tick();
    i_rd_valid = 1'b1;
    i_rd_data  = 16'hBEEF;
    tick();
    i_rd_valid = 1'b0;
    chk("rd_hi_start", 32'(o_tx_start), 32'd1);
    chk("rd_hi_data",  32'(o_tx_data),  32'hBE);
    finish_tx(4);
    chk("rd_lo_start", 32'(o_tx_start), 32'd1);
    chk("rd_lo_data",  32'(o_tx_data),  32'hEF);
    chk("rd_tx_count", 32'(tx_seen),    32'd2);
    finish_tx(2);

    // Unknown byte, then a write
    send(8'h41);
    chk("unk_err",   32'(o_err),       32'd1);
    chk("unk_valid", 32'(o_cmd_valid), 32'd0);
    tick();
    chk("unk_err_pulse", 32'(o_err), 32'd0);
    send(8'h57); send(8'h00); send(8'hAB); send(8'hCD); send(8'h12); send(8'h34);
    chk("wr2_flag",  32'(o_cmd_wr),    32'd1);
    chk("wr2_addr",  32'(o_cmd_addr),  32'h00ABCD);
    chk("wr2_wdata", 32'(o_cmd_wdata), 32'h1234);
    accept();
    chk("wr2_ack_data", 32'(o_tx_data), 32'h4B);
    finish_tx(2);

    // Timeout after a partial command
    send(8'h57); send(8'h12);
    for (int k = 1; k <= 3 * TO; k++) begin
      tick();
      if (o_err === 1'b1) begin
        wait_cycles = k;
        break;
      end
    end
    chk("timeout_cycles", 32'(wait_cycles), 32'(TO));
    tick();
    chk("timeout_err_pulse", 32'(o_err),       32'd0);
    chk("timeout_no_cmd",    32'(o_cmd_valid), 32'd0);

    // Read with a byte landing exactly on the expiry cycle
    send(8'h52); send(8'hAA);
    repeat (TO - 1) tick();
    send(8'hBB);
    chk("byte_wins_no_err", 32'(o_err), 32'd0);
    send(8'hCC);
    chk("rd2_valid", 32'(o_cmd_valid), 32'd1);
    chk("rd2_flag",  32'(o_cmd_wr),    32'd0);
    chk("rd2_addr",  32'(o_cmd_addr),  32'hAABBCC);
    accept();
    tick();
    tick();
    i_rd_valid = 1'b1;
    i_rd_data  = 16'h1234;
    tick();
    i_rd_valid = 1'b0;
    chk("rd2_hi_data", 32'(o_tx_data), 32'h12);
    finish_tx(2);
    chk("rd2_lo_data", 32'(o_tx_data), 32'h34);
    finish_tx(2);

    // Byte while the command is stalled
    send(8'h57); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    tick();
    send(8'h99);
    chk("stall_err",   32'(o_err),       32'd1);
    chk("stall_valid", 32'(o_cmd_valid), 32'd1);
    chk("stall_addr",  32'(o_cmd_addr),  32'h010203);
    chk("stall_wdata", 32'(o_cmd_wdata), 32'h0405);
    tick();
    accept();
    chk("stall_ack_data", 32'(o_tx_data), 32'h4B);
    finish_tx(2);

    // Reset while waiting for read data, then a stale response
    send(8'h52); send(8'h00); send(8'h00); send(8'h20);
    accept();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_all_zero("rst_abort");
    i_rd_valid = 1'b1;
    i_rd_data  = 16'hCAFE;
    tick();
    i_rd_valid = 1'b0;
    repeat (4) begin
      tick();
      chk("stale_no_start", 32'(o_tx_start), 32'd0);
    end
    chk("stale_txd", 32'(o_tx_data), 32'd0);

    chk("total_err_pulses", 32'(err_seen), 32'd3);
    chk("total_tx_starts",  32'(tx_seen),  32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser placed directly downstream of the UART receiver in the SDRAM test design. Consumes the receiver's one-cycle byte strobes, assembles write and read commands (command byte, 24-bit address, 16-bit data), issues them to the SDRAM controller over a valid/ready handshake, and returns an acknowledge byte or read data to the UART transmitter. Malformed, unknown, or stalled input is discarded and flagged on an error pulse.

## Interface
- `TIMEOUT_CLKS`, default 1_000_000: maximum inter-byte gap, in clocks, inside a partial command.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_rx_done`  in  1  one-cycle strobe from the UART receiver; byte valid.
- `i_rx_data`  in  8  received byte, valid while `i_rx_done`=1.
- `o_cmd_valid`  out  1  command request to the SDRAM controller.
- `i_cmd_ready`  in  1  controller accepts the command in any cycle where `o_cmd_valid` & `i_cmd_ready`.
- `o_cmd_wr`  out  1  1=write, 0=read.
- `o_cmd_addr`  out  24  word address.
- `o_cmd_wdata`  out  16  write data; 0 for reads.
- `i_rd_valid`  in  1  one-cycle read-data strobe from the controller.
- `i_rd_data`  in  16  read data, valid while `i_rd_valid`=1.
- `o_tx_start`  out  1  one-cycle request to the UART transmitter.
- `o_tx_data`  out  8  byte to transmit; held stable until the transmitter is idle again.
- `i_tx_busy`  in  1  transmitter busy; goes high no later than one cycle after `o_tx_start`.
- `o_err`  out  1  one-cycle pulse for any discarded input.

## Operation
- Protocol: `W`(0x57) A2 A1 A0 D1 D0 writes D1:D0 to A2:A1:A0. `R`(0x52) A2 A1 A0 reads. All fields are sent MSB first.
- Responses: a completed write returns 0x4B (`K`). A completed read returns the data high byte, then the low byte.
- State machine:
  - IDLE: on a byte, `W` or `R` → ADDR, with the byte counter cleared and the write flag latched. Any other byte pulses `o_err` and stays in IDLE.
  - ADDR: shift each byte into the address. After the 3rd byte, go to DATA for a write or ISSUE for a read.
  - DATA: shift each byte into the write data. After the 2nd byte → ISSUE.
  - ISSUE: `o_cmd_valid`=1 and all command fields held stable until accepted. On accept, a write goes to TX with byte 0x4B; a read goes to WAIT_RD.
  - WAIT_RD: on `i_rd_valid`, capture `i_rd_data` and go to TX with the high byte.
  - TX: pulse `o_tx_start` for one cycle → TX_WAIT.
  - TX_WAIT: one guard cycle, then wait for `i_tx_busy`=0. For a read whose high byte is done, return to TX with the low byte. Otherwise → IDLE.
- Timeout: a counter runs only in ADDR and DATA and reloads on every received byte. When it reaches `TIMEOUT_CLKS`-1: pulse `o_err`, discard the partial command, go to IDLE.
- Bytes arriving in ISSUE, WAIT_RD, TX, or TX_WAIT are dropped, and `o_err` pulses once per dropped byte.
- `i_rd_valid` outside WAIT_RD is ignored; this covers stale responses after reset.
- `i_cmd_ready` is ignored while `o_cmd_valid`=0.

## Timing
- Reset: state IDLE, counters 0, address/data registers 0. All outputs are 0: `o_cmd_valid`, `o_cmd_wr`, `o_cmd_addr`, `o_cmd_wdata`, `o_tx_start`, `o_tx_data`, `o_err`.
- Reset mid-command or mid-transfer aborts without a response. `o_cmd_valid` drops the cycle after `i_rst` is sampled high.
- Last parameter byte strobe at cycle N → `o_cmd_valid`=1 at N+1.
- Write accepted at cycle M → `o_tx_start` at M+1. `i_rd_valid` at cycle M → `o_tx_start` at M+1.
- `i_tx_busy` is first sampled two cycles after `o_tx_start`.
- If a byte strobe arrives in the same cycle the timeout expires, the byte wins: it is consumed and the counter reloads.
- `o_err` is a single-cycle pulse, registered, one cycle after the causing event.
- Address and data are shifted left by 8 bits per byte with new byte in the LSBs; no other arithmetic. The timeout counter width is `$clog2(TIMEOUT_CLKS)`.

## Structure
- Package `uart_cmd_pkg`:
  - command codes 0x57 and 0x52, ACK byte 0x4B;
  - `ADDR_BYTES`=3 and `DATA_BYTES`=2;
  - state encoding (IDLE, ADDR, DATA, ISSUE, WAIT_RD, TX, TX_WAIT).
- Sub-module `uart_cmd_timer`: loadable down-counter with inputs `i_clk`, `i_rst`, `i_run`, `i_reload`, and output `o_expired`. Instantiated once.
- Everything else stays in one FSM module.

## Test plan
- Write: bytes 57 12 34 56 AB CD → one command with `o_cmd_wr`=1, addr 0x123456, wdata 0xABCD, held until `i_cmd_ready`. Then one `o_tx_start` with data 0x4B.
- Read: bytes 52 00 00 10, controller returns 0xBEEF three cycles after accept → tx bytes 0xBE then 0xEF, second start only after `i_tx_busy` falls.
- Unknown byte 0x41 in IDLE → `o_err` pulse, no command. Following `W` command still parsed correctly.
- Bytes 57 12 then silence for `TIMEOUT_CLKS` → `o_err` at expiry, state IDLE. A following `R` command works.
- Byte sent while `o_cmd_valid` is stalled (ready held low) → byte dropped, `o_err`, command fields unchanged.
- `i_rst` asserted in WAIT_RD, then `i_rd_valid` pulses → all outputs 0, no transmit.
